// File: rtl/id_ex_stage.sv
// id_ex_stage
//   ID/EX pipeline register sitting directly in front of the EX-stage ALU.
//   - Captures decoded operands/control from ID, with a same-cycle WB bypass
//     into the captured register values.
//   - Detects load-use hazards: raises load_use_stall_o and inserts a bubble.
//   - flush_i squashes the instruction entering ID/EX (flush+stall = one bubble).
//   - Drives the ALU operands through an EX/MEM > MEM/WB forwarding network,
//     then through the pc/imm operand muxes.
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   id_*_i                   decoded instruction fields from ID
//   flush_i                  squash request (branch redirect)
//   exmem_*_i, memwb_*_i     downstream writers used for forwarding/bypass
//   load_use_stall_o         hold PC and IF/ID this cycle (combinational)
//   valid_ID_EX_o            EX holds a valid instruction
//   alu_in_rs1 / alu_in_rs2  ALU operands A/B (post-forward, post-mux)
//   alu_ctrl_ID_EX_o         ALU opcode to EX
//   rs2_fwd_ID_EX_o          forwarded rs2 (store data), never the immediate
//   rd_addr_ID_EX_o, reg_write_ID_EX_o, mem_read_ID_EX_o   control to EX/MEM
//
// Optional feature (macro ID_EX_PERF_CNT_EN):
//   adds stall_cnt_o / bubble_cnt_o, 32-bit wrapping counters cleared by rst.

module id_ex_stage #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  id_valid_i,
  input  logic [DATA_WIDTH-1:0] id_rs1_data_i,
  input  logic [DATA_WIDTH-1:0] id_rs2_data_i,
  input  logic [DATA_WIDTH-1:0] id_imm_i,
  input  logic [DATA_WIDTH-1:0] id_pc_i,
  input  logic [REG_ADDR_W-1:0] id_rs1_addr_i,
  input  logic [REG_ADDR_W-1:0] id_rs2_addr_i,
  input  logic [REG_ADDR_W-1:0] id_rd_addr_i,
  input  logic [3:0]            id_alu_ctrl_i,
  input  logic                  id_use_imm_i,
  input  logic                  id_use_pc_i,
  input  logic                  id_mem_read_i,
  input  logic                  id_reg_write_i,
  input  logic                  flush_i,
  input  logic [REG_ADDR_W-1:0] exmem_rd_addr_i,
  input  logic                  exmem_reg_write_i,
  input  logic [DATA_WIDTH-1:0] exmem_alu_res_i,
  input  logic [REG_ADDR_W-1:0] memwb_rd_addr_i,
  input  logic                  memwb_reg_write_i,
  input  logic [DATA_WIDTH-1:0] memwb_wdata_i,
  output logic                  load_use_stall_o,
  output logic                  valid_ID_EX_o,
  output logic [DATA_WIDTH-1:0] alu_in_rs1,
  output logic [DATA_WIDTH-1:0] alu_in_rs2,
  output logic [3:0]            alu_ctrl_ID_EX_o,
  output logic [DATA_WIDTH-1:0] rs2_fwd_ID_EX_o,
  output logic [REG_ADDR_W-1:0] rd_addr_ID_EX_o,
  output logic                  reg_write_ID_EX_o,
  output logic                  mem_read_ID_EX_o
`ifdef ID_EX_PERF_CNT_EN
  ,
  output logic [31:0]           stall_cnt_o,
  output logic [31:0]           bubble_cnt_o
`endif
);

  typedef struct packed {
    logic                  valid;
    logic                  mem_read;
    logic                  reg_write;
    logic                  use_imm;
    logic                  use_pc;
    logic [3:0]            alu_ctrl;
    logic [REG_ADDR_W-1:0] rd;
    logic [REG_ADDR_W-1:0] rs1;
    logic [REG_ADDR_W-1:0] rs2;
    logic [DATA_WIDTH-1:0] rs1_data;
    logic [DATA_WIDTH-1:0] rs2_data;
    logic [DATA_WIDTH-1:0] imm;
    logic [DATA_WIDTH-1:0] pc;
  } id_ex_t;

  id_ex_t id_ex_q, id_ex_d;

  logic                  stall;
  logic                  bubble_ins;
  logic [DATA_WIDTH-1:0] fwd_rs1, fwd_rs2;

  // Load in EX whose destination is read by the instruction in ID.
  assign stall = id_ex_q.valid && id_ex_q.mem_read && (id_ex_q.rd != '0) && id_valid_i &&
                 ((id_ex_q.rd == id_rs1_addr_i) || (id_ex_q.rd == id_rs2_addr_i));

  assign bubble_ins       = flush_i || stall;
  assign load_use_stall_o = stall;

  // Anything other than a clean capture latches an all-zero bubble.
  always_comb begin
    id_ex_d = '0;
    if (!bubble_ins && id_valid_i) begin
      id_ex_d.valid     = 1'b1;
      id_ex_d.mem_read  = id_mem_read_i;
      id_ex_d.reg_write = id_reg_write_i;
      id_ex_d.use_imm   = id_use_imm_i;
      id_ex_d.use_pc    = id_use_pc_i;
      id_ex_d.alu_ctrl  = id_alu_ctrl_i;
      id_ex_d.rd        = id_rd_addr_i;
      id_ex_d.rs1       = id_rs1_addr_i;
      id_ex_d.rs2       = id_rs2_addr_i;
      id_ex_d.imm       = id_imm_i;
      id_ex_d.pc        = id_pc_i;
      // Regfile was read before this cycle's WB write landed; bypass it.
      if (memwb_reg_write_i && (memwb_rd_addr_i != '0) && (memwb_rd_addr_i == id_rs1_addr_i))
        id_ex_d.rs1_data = memwb_wdata_i;
      else
        id_ex_d.rs1_data = id_rs1_data_i;
      if (memwb_reg_write_i && (memwb_rd_addr_i != '0) && (memwb_rd_addr_i == id_rs2_addr_i))
        id_ex_d.rs2_data = memwb_wdata_i;
      else
        id_ex_d.rs2_data = id_rs2_data_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) id_ex_q <= '0;
    else     id_ex_q <= id_ex_d;
  end

  // Forwarding: x0 always reads zero; EX/MEM is younger so it beats MEM/WB.
  always_comb begin
    fwd_rs1 = id_ex_q.rs1_data;
    if (id_ex_q.rs1 == '0)
      fwd_rs1 = '0;
    else if (exmem_reg_write_i && (exmem_rd_addr_i != '0) && (exmem_rd_addr_i == id_ex_q.rs1))
      fwd_rs1 = exmem_alu_res_i;
    else if (memwb_reg_write_i && (memwb_rd_addr_i != '0) && (memwb_rd_addr_i == id_ex_q.rs1))
      fwd_rs1 = memwb_wdata_i;
  end

  always_comb begin
    fwd_rs2 = id_ex_q.rs2_data;
    if (id_ex_q.rs2 == '0)
      fwd_rs2 = '0;
    else if (exmem_reg_write_i && (exmem_rd_addr_i != '0) && (exmem_rd_addr_i == id_ex_q.rs2))
      fwd_rs2 = exmem_alu_res_i;
    else if (memwb_reg_write_i && (memwb_rd_addr_i != '0) && (memwb_rd_addr_i == id_ex_q.rs2))
      fwd_rs2 = memwb_wdata_i;
  end

  assign alu_in_rs1        = id_ex_q.use_pc  ? id_ex_q.pc  : fwd_rs1;
  assign alu_in_rs2        = id_ex_q.use_imm ? id_ex_q.imm : fwd_rs2;
  assign rs2_fwd_ID_EX_o   = fwd_rs2;
  assign valid_ID_EX_o     = id_ex_q.valid;
  assign alu_ctrl_ID_EX_o  = id_ex_q.alu_ctrl;
  assign rd_addr_ID_EX_o   = id_ex_q.rd;
  assign reg_write_ID_EX_o = id_ex_q.reg_write;
  assign mem_read_ID_EX_o  = id_ex_q.mem_read;

`ifdef ID_EX_PERF_CNT_EN
  logic [31:0] stall_cnt_q, bubble_cnt_q;

  // Bubbles counted are the inserted ones (flush/stall), not idle ID slots.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      if (stall)      stall_cnt_q  <= stall_cnt_q + 32'd1;
      if (bubble_ins) bubble_cnt_q <= bubble_cnt_q + 32'd1;
    end
  end

  assign stall_cnt_o  = stall_cnt_q;
  assign bubble_cnt_o = bubble_cnt_q;
`endif

endmodule
